// File: rtl/spmm_idx_pkg.sv
// Shared types and constants for the sparse-row index expansion path.
package spmm_idx_pkg;

    // Comparator result codes, relative to the reference position.
    localparam logic [1:0] CMP_LT = 2'b01;  // reference position below input index
    localparam logic [1:0] CMP_EQ = 2'b10;  // reference position equals input index
    localparam logic [1:0] CMP_GT = 2'b11;  // reference position past input index

    typedef enum logic [2:0] {
        IDLE,
        EXPAND,
        FILL,
        DRAIN,
        DONE
    } ctrl_state_t;

endpackage

// File: rtl/idx_expand_ctrl_cmp.sv
// Index comparator: classifies the reference position against an input index.
module idx_expand_ctrl_cmp
    import spmm_idx_pkg::*;
#(
    parameter int ip_width_param = 4
) (
    input  logic [ip_width_param-1:0] d0,
    input  logic [ip_width_param-1:0] d1_ref,
    output logic [1:0]                code
);

    // Pure combinational magnitude compare.
    always_comb begin
        if (d1_ref < d0) begin
            code = CMP_LT;
        end else if (d1_ref == d0) begin
            code = CMP_EQ;
        end else begin
            code = CMP_GT;
        end
    end

endmodule

// File: rtl/idx_expand_ctrl.sv
// Expands one compressed sparse row into a dense, position-ordered stream.
module idx_expand_ctrl
    import spmm_idx_pkg::*;
#(
    parameter int IDX_W  = 4,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [IDX_W:0]    row_len,
    input  logic              row_empty,
    output logic              busy,
    output logic              done,
    output logic              err,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [IDX_W-1:0]  in_idx,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [IDX_W-1:0]  out_pos,
    output logic [DATA_W-1:0] out_data,
    output logic              out_hit,
    output logic              out_last
);

    ctrl_state_t    state;
    logic [IDX_W:0] pos;
    logic [IDX_W:0] len;
    logic [IDX_W:0] pos_inc;
    logic           in_done;    // final input element already consumed
    logic           last_done;  // out_last already handshaken (or row has no positions)
    logic [1:0]     cmp_code;
    logic           adv;
    logic           more_pos;
    logic           emit;
    logic           emit_hit;
    logic           drop;
    logic           in_take;
    logic           last_hs;
    logic           in_fin;
    logic           last_fin;

    idx_expand_ctrl_cmp #(
        .ip_width_param (IDX_W)
    ) u_cmp (
        .d0     (in_idx),
        .d1_ref (pos[IDX_W-1:0]),
        .code   (cmp_code)
    );

    assign busy = (state != IDLE);

    // Per-cycle decisions: what to emit, whether to take or drop the input.
    always_comb begin
        // NOTE: every signal written here gets a default first so no path infers a latch.
        adv      = !out_valid || out_ready;
        more_pos = pos < len;
        pos_inc  = pos + 1'b1;
        in_ready = 1'b0;
        emit     = 1'b0;
        emit_hit = 1'b0;
        drop     = 1'b0;
        case (state)
            EXPAND: begin
                if (in_valid && adv && more_pos) begin
                    case (cmp_code)
                        CMP_LT: emit = 1'b1;
                        CMP_EQ: begin
                            emit     = 1'b1;
                            emit_hit = 1'b1;
                            in_ready = 1'b1;
                        end
                        default: begin
                            drop     = 1'b1;
                            in_ready = 1'b1;
                        end
                    endcase
                end
            end
            FILL:    emit = adv && more_pos;
            DRAIN:   in_ready = !in_done;
            default: ;
        endcase
    end

    // Completion terms include handshakes happening this cycle so done lands one cycle later.
    assign in_take  = in_valid && in_ready;
    assign last_hs  = out_valid && out_ready && out_last;
    assign in_fin   = in_done || (in_take && in_last);
    assign last_fin = last_done || last_hs;

    // Sequencer state, position counter, sticky error and the single output register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            pos       <= '0;
            len       <= '0;
            in_done   <= 1'b0;
            last_done <= 1'b0;
            err       <= 1'b0;
            done      <= 1'b0;
            out_valid <= 1'b0;
            out_pos   <= '0;
            out_data  <= '0;
            out_hit   <= 1'b0;
            out_last  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments throughout, so later statements override earlier defaults cleanly.
            done <= 1'b0;
            if (adv) begin
                out_valid <= 1'b0;
            end
            if (emit) begin
                out_valid <= 1'b1;
                out_pos   <= pos[IDX_W-1:0];
                out_data  <= emit_hit ? in_data : '0;
                out_hit   <= emit_hit;
                out_last  <= (pos_inc == len);
                pos       <= pos_inc;
            end
            if (drop || (state == DRAIN && in_take)) begin
                err <= 1'b1;
            end
            if (in_take && in_last) begin
                in_done <= 1'b1;
            end
            if (last_hs) begin
                last_done <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (start) begin
                        err       <= 1'b0;
                        pos       <= '0;
                        len       <= row_len;
                        in_done   <= row_empty;
                        last_done <= (row_len == '0);
                        if (row_len == '0 && row_empty) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else if (row_len == '0) begin
                            state <= DRAIN;
                        end else if (row_empty) begin
                            state <= FILL;
                        end else begin
                            state <= EXPAND;
                        end
                    end
                end
                EXPAND: begin
                    if (in_take && in_last) begin
                        state <= FILL;
                    end else if (emit && pos_inc == len) begin
                        state <= DRAIN;
                    end
                end
                FILL, DRAIN: begin
                    if (in_fin && last_fin) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_idx_expand_ctrl.sv
// Directed scoreboard bench for idx_expand_ctrl.
module tb_idx_expand_ctrl;

    localparam int IDX_W  = 4;
    localparam int DATA_W = 16;

    typedef struct packed {
        logic [IDX_W-1:0]  pos;
        logic [DATA_W-1:0] data;
        logic              hit;
        logic              last;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic [IDX_W:0]    row_len = '0;
    logic              row_empty = 1'b0;
    logic              busy;
    logic              done;
    logic              err;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [IDX_W-1:0]  in_idx = '0;
    logic [DATA_W-1:0] in_data = '0;
    logic              in_last = 1'b0;
    logic              out_valid;
    logic              out_ready;
    logic [IDX_W-1:0]  out_pos;
    logic [DATA_W-1:0] out_data;
    logic              out_hit;
    logic              out_last;

    exp_t exp_q[$];
    exp_t mon_e;
    exp_t stall_val;
    logic stall_prev = 1'b0;
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   last_out_cyc = -1;
    int   last_in_cyc = -1;
    bit   mon_en = 1'b0;
    bit   bp_en = 1'b0;
    bit   ready_seen = 1'b0;

    idx_expand_ctrl #(
        .IDX_W  (IDX_W),
        .DATA_W (DATA_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .row_len   (row_len),
        .row_empty (row_empty),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_idx    (in_idx),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_pos   (out_pos),
        .out_data  (out_data),
        .out_hit   (out_hit),
        .out_last  (out_last)
    );

    initial forever #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Downstream sink: out_ready is either held high or toggled every cycle.
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            out_ready = bp_en ? !out_ready : 1'b1;
        end
    end

    // Output monitor: scoreboard pop on handshake, stability check across stalls.
    always @(negedge clk) begin
        if (rst_n && in_ready) ready_seen = 1'b1;
        if (mon_en && rst_n) begin
            if (stall_prev && out_valid) begin
                check("stall_pos", out_pos, stall_val.pos);
                check("stall_data", out_data, stall_val.data);
                check("stall_hit", out_hit, stall_val.hit);
                check("stall_last", out_last, stall_val.last);
            end
            if (out_valid && out_ready) begin
                check("out_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    mon_e = exp_q.pop_front();
                    check("out_pos", out_pos, mon_e.pos);
                    check("out_data", out_data, mon_e.data);
                    check("out_hit", out_hit, mon_e.hit);
                    check("out_last", out_last, mon_e.last);
                end
                if (out_last) last_out_cyc = cyc;
            end
            stall_prev = out_valid && !out_ready;
            stall_val  = '{out_pos, out_data, out_hit, out_last};
        end else begin
            stall_prev = 1'b0;
        end
    end

    task automatic push_exp(input int p, input int d, input bit h, input bit l);
        exp_t e;
        e.pos  = p[IDX_W-1:0];
        e.data = d[DATA_W-1:0];
        e.hit  = h;
        e.last = l;
        exp_q.push_back(e);
    endtask

    task automatic start_row(input logic [IDX_W:0] len, input bit empty);
        @(posedge clk);
        #1;
        start        = 1'b1;
        row_len      = len;
        row_empty    = empty;
        last_in_cyc  = -1;
        last_out_cyc = -1;
        ready_seen   = 1'b0;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("busy_after_start", busy, 1);
        check("no_early_out", out_valid, 0);
        check("err_clear_on_start", err, 0);
    endtask

    task automatic send(input int idx, input int data, input bit last);
        bit acc = 1'b0;
        int n = 0;
        in_valid = 1'b1;
        in_idx   = idx[IDX_W-1:0];
        in_data  = data[DATA_W-1:0];
        in_last  = last;
        while (!acc && n < 200) begin
            @(negedge clk);
            acc = in_ready;
            if (acc && last) last_in_cyc = cyc;
            n++;
            @(posedge clk);
            #1;
        end
        check("in_accept", acc, 1);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_done(input bit exp_err);
        bit seen = 1'b0;
        int n = 0;
        int later;
        while (!seen && n < 300) begin
            @(negedge clk);
            n++;
            if (done) seen = 1'b1;
        end
        check("done_seen", seen, 1);
        if (seen) begin
            later = (last_out_cyc > last_in_cyc) ? last_out_cyc : last_in_cyc;
            check("done_timing", cyc, later + 1);
            check("err_at_done", err, exp_err);
            check("queue_empty", exp_q.size(), 0);
            @(negedge clk);
            check("done_pulse_width", done, 0);
            check("idle_after_done", busy, 0);
        end
    endtask

    task automatic basic_row();
        push_exp(0, 0, 0, 0);
        push_exp(1, 'hA, 1, 0);
        push_exp(2, 0, 0, 0);
        push_exp(3, 'hB, 1, 1);
        start_row(5'd4, 1'b0);
        send(1, 'hA, 1'b0);
        send(3, 'hB, 1'b1);
        wait_done(1'b0);
    endtask

    initial begin
        #12;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 0);
        rst_n  = 1'b1;
        mon_en = 1'b1;

        // Basic expand with an always-ready sink.
        basic_row();

        // Same row under toggling backpressure.
        bp_en = 1'b1;
        basic_row();
        bp_en = 1'b0;

        // Empty row: pure zero fill, input never accepted.
        push_exp(0, 0, 0, 0);
        push_exp(1, 0, 0, 0);
        push_exp(2, 0, 0, 1);
        start_row(5'd3, 1'b1);
        wait_done(1'b0);
        check("empty_in_ready_never", ready_seen, 0);

        // Out-of-order and duplicate indices are dropped.
        push_exp(0, 0, 0, 0);
        push_exp(1, 0, 0, 0);
        push_exp(2, 'h5, 1, 0);
        push_exp(3, 0, 0, 1);
        start_row(5'd4, 1'b0);
        send(2, 'h5, 1'b0);
        send(2, 'h6, 1'b0);
        send(1, 'h7, 1'b1);
        wait_done(1'b1);

        // Index beyond the row is drained after the last position.
        push_exp(0, 'h9, 1, 0);
        push_exp(1, 0, 0, 1);
        start_row(5'd2, 1'b0);
        send(0, 'h9, 1'b0);
        send(5, 'h3, 1'b1);
        wait_done(1'b1);

        // Asynchronous reset in the middle of an expansion.
        mon_en = 1'b0;
        start_row(5'd4, 1'b0);
        in_valid = 1'b1;
        in_idx   = 4'd3;
        in_data  = 16'h77;
        in_last  = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        check("busy_before_reset", busy, 1);
        check("out_valid_before_reset", out_valid, 1);
        rst_n = 1'b0;
        #1;
        check("reset_busy", busy, 0);
        check("reset_out_valid", out_valid, 0);
        check("reset_done", done, 0);
        check("reset_err", err, 0);
        in_valid = 1'b0;
        exp_q.delete();
        @(posedge clk);
        #1;
        rst_n  = 1'b1;
        mon_en = 1'b1;
        basic_row();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
